// File: rtl/score_register_file_if.sv
// Bus bundle for the score register file: write/read requests in, read data and log status out.
interface score_register_file_if #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 8
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] i_in;
    logic             i_load;
    logic [AW-1:0]    i_wr_addr;
    logic             i_push;
    logic [AW-1:0]    i_rd_addr_a;
    logic [AW-1:0]    i_rd_addr_b;
    logic [WIDTH-1:0] o_qa;
    logic [WIDTH-1:0] o_qb;
    logic [AW-1:0]    o_wr_ptr;
    logic [AW:0]      o_count;
    logic             o_full;
    logic [WIDTH-1:0] o_min_q;
    logic             o_min_valid;

    modport master (
        output i_in, i_load, i_wr_addr, i_push, i_rd_addr_a, i_rd_addr_b,
        input  o_qa, o_qb, o_wr_ptr, o_count, o_full, o_min_q, o_min_valid
    );

    modport slave (
        input  i_in, i_load, i_wr_addr, i_push, i_rd_addr_a, i_rd_addr_b,
        output o_qa, o_qb, o_wr_ptr, o_count, o_full, o_min_q, o_min_valid
    );
endinterface

// File: rtl/score_register_file.sv
// Multi-row score register file: addressed Load, circular Push log, two registered
// read ports with write-first bypass, entry count and best (minimum) pushed time.
module score_register_file #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 8
) (
    input  logic                  i_clock,
    input  logic                  i_clr,
    score_register_file_if.slave  bus
);
    localparam int             AW        = $clog2(DEPTH);
    localparam logic [AW:0]    DEPTH_CNT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]  LAST_ROW  = AW'(DEPTH-1);

    logic [WIDTH-1:0] r_rows [DEPTH];
    logic [WIDTH-1:0] r_qa;
    logic [WIDTH-1:0] r_qb;
    logic [WIDTH-1:0] r_min_q;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW:0]      r_count;
    logic             r_min_valid;

    logic             w_wr_addr_ok;
    logic             w_rd_a_ok;
    logic             w_rd_b_ok;
    logic             w_load_ok;
    logic             w_push_ok;
    logic             w_min_take;
    logic             w_hit_a;
    logic             w_hit_b;
    logic [DEPTH-1:0] w_row_we;
    logic [WIDTH-1:0] w_qa_next;
    logic [WIDTH-1:0] w_qb_next;

    // Addresses can exceed DEPTH-1 only when DEPTH is not a power of two.
    assign w_wr_addr_ok = int'(bus.i_wr_addr)   < DEPTH;
    assign w_rd_a_ok    = int'(bus.i_rd_addr_a) < DEPTH;
    assign w_rd_b_ok    = int'(bus.i_rd_addr_b) < DEPTH;

    // Load has priority; a Push coinciding with any Load is dropped entirely.
    assign w_load_ok  = bus.i_load && w_wr_addr_ok;
    assign w_push_ok  = bus.i_push && !bus.i_load;
    assign w_min_take = w_push_ok && (!r_min_valid || (bus.i_in < r_min_q));

    // Same-cycle write to the addressed row forwards the write data to the read port.
    assign w_hit_a = (w_load_ok && (bus.i_wr_addr == bus.i_rd_addr_a)) ||
                     (w_push_ok && (r_wr_ptr == bus.i_rd_addr_a));
    assign w_hit_b = (w_load_ok && (bus.i_wr_addr == bus.i_rd_addr_b)) ||
                     (w_push_ok && (r_wr_ptr == bus.i_rd_addr_b));

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_row_we
            assign w_row_we[gi] = (w_load_ok && (bus.i_wr_addr == AW'(gi))) ||
                                  (w_push_ok && (r_wr_ptr == AW'(gi)));
        end
    endgenerate

    // Next read data: bypass on write hit, else the stored row, else 0 when out of range.
    always_comb begin
        w_qa_next = '0;
        w_qb_next = '0;
        if (w_hit_a) begin
            w_qa_next = bus.i_in;
        end else if (w_rd_a_ok) begin
            w_qa_next = r_rows[bus.i_rd_addr_a];
        end
        if (w_hit_b) begin
            w_qb_next = bus.i_in;
        end else if (w_rd_b_ok) begin
            w_qb_next = r_rows[bus.i_rd_addr_b];
        end
    end

    // Row storage; clear wipes every row and discards that cycle's write.
    always_ff @(posedge i_clock) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (i_clr) begin
                r_rows[i] <= '0;
            end else if (w_row_we[i]) begin
                r_rows[i] <= bus.i_in;
            end
        end
    end

    // Read ports, push pointer, saturating entry count and running minimum since clear.
    always_ff @(posedge i_clock) begin
        if (i_clr) begin
            r_qa        <= '0;
            r_qb        <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_min_q     <= '0;
            r_min_valid <= 1'b0;
        end else begin
            r_qa <= w_qa_next;
            r_qb <= w_qb_next;
            if (w_push_ok) begin
                r_wr_ptr    <= (r_wr_ptr == LAST_ROW) ? '0 : r_wr_ptr + 1'b1;
                r_min_valid <= 1'b1;
                if (r_count != DEPTH_CNT) begin
                    r_count <= r_count + 1'b1;
                end
            end
            if (w_min_take) begin
                r_min_q <= bus.i_in;
            end
        end
    end

    assign bus.o_qa        = r_qa;
    assign bus.o_qb        = r_qb;
    assign bus.o_wr_ptr    = r_wr_ptr;
    assign bus.o_count     = r_count;
    assign bus.o_full      = (r_count == DEPTH_CNT);
    assign bus.o_min_q     = r_min_q;
    assign bus.o_min_valid = r_min_valid;
endmodule

// File: doc/score_register_file.md
Name: score_register_file

Overview:
- Parametrised multi-row register file. It is the successor to the single 13-bit load/clear register row used by the reaction-time game.
- Holds DEPTH rows of WIDTH bits with two registered read ports.
- Supports two write modes: addressed Load, and a circular Push log for successive reaction-time results.
- Tracks the number of logged entries and the minimum pushed value (the best time) for the scoreboard/display logic.

Parameters:
- WIDTH, 13, bits per row (reaction-time count width).
- DEPTH, 8, number of rows; must be ≥2. AW = clog2(DEPTH) is derived internally.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- CLR  in  1  synchronous, active-high clear.
- In  in  WIDTH  write data, used by both Load and Push.
- Load  in  1  addressed write of In to row WrAddr.
- WrAddr  in  AW  row index for Load.
- Push  in  1  circular-log write of In to row WrPtr.
- RdAddrA  in  AW  read address, port A.
- RdAddrB  in  AW  read address, port B.
- QA  out  WIDTH  registered read data, port A.
- QB  out  WIDTH  registered read data, port B.
- WrPtr  out  AW  next Push target row.
- Count  out  AW+1  valid logged entries, saturating at DEPTH.
- Full  out  1  high when Count == DEPTH.
- MinQ  out  WIDTH  smallest value pushed since the last clear.
- MinValid  out  1  high once at least one Push has been accepted.

Behaviour:
- Reset: a CLR sampled high at the edge sets all rows, QA, QB, WrPtr, Count, MinQ and MinValid to 0 and Full to 0.
  - CLR overrides Load and Push in the same cycle.
  - CLR mid-operation discards that cycle's write.
- Load: when Load=1, row[WrAddr] <= In. WrPtr, Count and Min are unchanged.
- Push: when Push=1 and Load=0:
  - row[WrPtr] <= In.
  - WrPtr <= WrPtr+1, wrapping from DEPTH-1 to 0.
  - Count <= min(Count+1, DEPTH).
- Push while Full: still writes and advances, overwriting the oldest entry. Count stays at DEPTH.
- Simultaneous Load and Push: Load wins and the Push is dropped entirely. No write at WrPtr, no pointer or Count change, no Min update.
- Non-power-of-two DEPTH: WrPtr wraps at DEPTH-1.
- Out-of-range addresses (≥DEPTH):
  - A Load to such an address is ignored.
  - A read returns 0.
- Minimum tracking, on each accepted Push:
  - If MinValid=0 or In < MinQ: MinQ <= In.
  - MinValid <= 1.
  - Comparison is unsigned.
  - An equal value leaves MinQ unchanged.
  - Load never affects MinQ, even if it overwrites the row holding the minimum.
  - An overwrite on wrap does not recompute MinQ; MinQ is the minimum since clear.
- Reads: QA <= row[RdAddrA] and QB <= row[RdAddrB] every cycle, giving 1-cycle latency.
- Write-first bypass: if a write (Load or accepted Push) targets the read address in the same cycle, QA/QB take In in that cycle.
- Both read ports may address the same row.
- Full is combinational from Count. WrPtr and Count are registered.

Test Plan:
- Reset: Load row 3 with 0x1ABC, then assert CLR for 1 cycle. Read row 3 → QA=0, Count=0, MinValid=0, WrPtr=0.
- Addressed load and dual read: Load 0x0123→row2 and 0x1FFF→row5. Set RdAddrA=2, RdAddrB=5 → one cycle later QA=0x0123, QB=0x1FFF. Count stays 0.
- Push and wrap with DEPTH=8: push 500,300,700,250,900,400,600,800 → Full=1, WrPtr=0, MinQ=250. Push 100 → row0=100, WrPtr=1, Count=8, MinQ=100.
- Simultaneous events: Load=1 to WrAddr=4 with In=50 and Push=1 → row4=50, WrPtr/Count unchanged, MinQ unchanged (not 50).
- Bypass: RdAddrA=WrPtr=3 while pushing 0x0AAA → QA=0x0AAA on the next cycle.
- Clear mid-operation: Push 777 and CLR in the same cycle → row0=0, Count=0, MinValid=0.
